// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: register-bank operand fetch with RAW/WAW scoreboard and a 2-entry output FIFO (writeback bypass when OPFETCH_WB_BYPASS_EN is defined)
module operand_fetch_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic              in_uses_rt,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [ADDR_W-1:0] regAddr_1,
    output logic [ADDR_W-1:0] regAddr_2,
    output logic              flag,
    input  logic [DATA_W-1:0] regReadData_1,
    input  logic [DATA_W-1:0] regReadData_2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_we,
    output logic [CTRL_W-1:0] out_ctrl
);
    localparam int NR = 1 << ADDR_W;
    localparam int EW = 2 * DATA_W + ADDR_W + 1 + CTRL_W;

    logic [NR-1:0]     sb, sb_nxt;
    logic [1:0]        count;
    logic [EW-1:0]     e0, e1, ent;
    logic              c1, c2, cd, wb_stall, f1, f2;
    logic              hz1, hz2, hzw, acc, pop;
    logic [DATA_W-1:0] op1, op2;

`ifdef OPFETCH_WB_BYPASS_EN
    assign c1       = wb_en && wb_addr == in_rs && sb[in_rs];
    assign c2       = wb_en && wb_addr == in_rt && sb[in_rt];
    assign cd       = wb_en && wb_addr == in_rd && sb[in_rd];
    assign wb_stall = 1'b0;
    assign f1       = wb_en && wb_addr == in_rs;
    assign f2       = wb_en && wb_addr == in_rt;
`else
    assign c1       = 1'b0;
    assign c2       = 1'b0;
    assign cd       = 1'b0;
    assign wb_stall = wb_en && (wb_addr == in_rs || (in_uses_rt && wb_addr == in_rt));
    assign f1       = 1'b0;
    assign f2       = 1'b0;
`endif

    assign regAddr_1 = in_rs;
    assign regAddr_2 = in_rt;
    assign flag      = in_uses_rt;

    assign hz1      = sb[in_rs] && !c1;
    assign hz2      = in_uses_rt && sb[in_rt] && !c2;
    assign hzw      = in_we && sb[in_rd] && !cd;
    assign in_ready = rst && count != 2'd2 && !hz1 && !hz2 && !hzw && !wb_stall;
    assign acc      = in_valid && in_ready;
    assign out_valid = count != 2'd0;
    assign pop      = out_valid && out_ready;

    assign op1 = f1 ? wb_data : regReadData_1;
    assign op2 = in_uses_rt ? (f2 ? wb_data : regReadData_2) : in_imm;
    assign ent = {op1, op2, in_rd, in_we, in_ctrl};
    assign {out_op1, out_op2, out_rd, out_we, out_ctrl} = e0;

    // scoreboard next state: retire the writeback first so a new producer of the same register wins
    always_comb begin
        sb_nxt = sb;
        if (wb_en) sb_nxt[wb_addr] = 1'b0;
        if (acc && in_we) sb_nxt[in_rd] = 1'b1;
    end

    // FIFO (e0 is the head) and scoreboard state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb    <= '0;
            count <= '0;
            e0    <= '0;
            e1    <= '0;
        end else begin
            sb    <= sb_nxt;
            count <= count + 2'(acc) - 2'(pop);
            e0    <= pop ? (count == 2'd2 ? e1 : (acc ? ent : e0)) : (acc && count == 2'd0 ? ent : e0);
            e1    <= (acc && !pop && count == 2'd1) ? ent : e1;
        end
    end
endmodule
